// File: rtl/fft_col_sched_if.sv
// Control bus between the FFT top-level control (master) and the MAC column
// scheduler (slave): start/abort/ack requests in, phase/twiddle/capture strobes out.
interface fft_col_sched_if #(
  parameter int SEL_W = 2,
  parameter int TW_W  = 3,
  parameter int STG_W = 2
);
  logic             i_start;
  logic             i_abort;
  logic             i_ack;
  logic [SEL_W-1:0] o_mac_sel;
  logic [TW_W-1:0]  o_tw_idx;
  logic [STG_W-1:0] o_stage;
  logic             o_ld_en;
  logic             o_issue;
  logic             o_cap_en;
  logic [SEL_W-1:0] o_cap_sel;
  logic             o_bank_swap;
  logic             o_busy;
  logic             o_done;
  logic [15:0]      o_perf_cycles;

  modport master (
    output i_start, i_abort, i_ack,
    input  o_mac_sel, o_tw_idx, o_stage, o_ld_en, o_issue, o_cap_en, o_cap_sel,
           o_bank_swap, o_busy, o_done, o_perf_cycles
  );

  modport slave (
    input  i_start, i_abort, i_ack,
    output o_mac_sel, o_tw_idx, o_stage, o_ld_en, o_issue, o_cap_en, o_cap_sel,
           o_bank_swap, o_busy, o_done, o_perf_cycles
  );
endinterface

// File: rtl/fft_col_sched.sv
// Radix-2 FFT MAC-column sequencer: LOAD, per-stage RUN/DRAIN phase stepping, DONE/ack.
// Optional busy-cycle counter on o_perf_cycles when FFT_COL_SCHED_PERF_EN is defined.
module fft_col_sched #(
  parameter int PHASES     = 4,
  parameter int NUM_STAGES = 3,
  parameter int MAC_LAT    = 1,
  parameter int TW_W       = 3
) (
  input  logic           clk,
  input  logic           reset,
  fft_col_sched_if.slave bus
);
  localparam int SEL_W   = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int STG_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int TW_FULL = TW_W + SEL_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [SEL_W-1:0] r_phase, w_phase_next;
  logic [STG_W-1:0] r_stage, w_stage_next;
  logic [2:0]       r_drain, w_drain_next;

  logic             w_ld_en, w_issue, w_bank_swap, w_busy, w_done, w_flush;
  logic [SEL_W-1:0] w_mac_sel;
  logic [TW_W-1:0]  w_tw_idx;
  logic [STG_W-1:0] w_shamt;
  logic [TW_FULL-1:0] w_tw_wide;

  // Later stages use finer twiddle spacing: shift shrinks as stage grows.
  assign w_shamt   = STG_W'(NUM_STAGES - 1) - r_stage;
  assign w_tw_wide = TW_FULL'(r_phase) << w_shamt;
  assign w_flush   = bus.i_abort && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_stage <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_stage <= w_stage_next;
      r_drain <= w_drain_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_stage_next = r_stage;
    w_drain_next = r_drain;
    w_ld_en      = 1'b0;
    w_issue      = 1'b0;
    w_bank_swap  = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_mac_sel    = '0;
    w_tw_idx     = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_ld_en      = 1'b1;
        w_busy       = 1'b1;
        w_phase_next = '0;
        w_stage_next = '0;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        w_busy    = 1'b1;
        w_issue   = 1'b1;
        w_mac_sel = r_phase;
        w_tw_idx  = w_tw_wide[TW_W-1:0];
        if (r_phase == SEL_W'(PHASES - 1)) begin
          w_phase_next = '0;
          w_drain_next = '0;
          w_state_next = S_DRAIN;
        end else begin
          w_phase_next = r_phase + 1'b1;
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (r_drain == 3'(MAC_LAT)) begin
          if (r_stage < STG_W'(NUM_STAGES - 1)) begin
            w_bank_swap  = 1'b1;
            w_stage_next = r_stage + 1'b1;
            w_state_next = S_RUN;
          end else begin
            w_state_next = S_DONE;
          end
        end else begin
          w_drain_next = r_drain + 1'b1;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (bus.i_ack) begin
          w_state_next = S_IDLE;
          w_stage_next = '0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // Abort wins over every advance, including a pending bank swap.
    if (w_flush) begin
      w_state_next = S_IDLE;
      w_phase_next = '0;
      w_stage_next = '0;
      w_drain_next = '0;
      w_bank_swap  = 1'b0;
    end
  end

  generate
    if (MAC_LAT == 0) begin : g_nodly
      assign bus.o_cap_en  = w_issue;
      assign bus.o_cap_sel = w_mac_sel;
    end else begin : g_dly
      logic             r_iss_dly [MAC_LAT];
      logic [SEL_W-1:0] r_sel_dly [MAC_LAT];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset || w_flush) begin
          for (int i = 0; i < MAC_LAT; i++) begin
            r_iss_dly[i] <= 1'b0;
            r_sel_dly[i] <= '0;
          end
        end else begin
          r_iss_dly[0] <= w_issue;
          r_sel_dly[0] <= w_mac_sel;
          for (int i = 1; i < MAC_LAT; i++) begin
            r_iss_dly[i] <= r_iss_dly[i-1];
            r_sel_dly[i] <= r_sel_dly[i-1];
          end
        end
      end
      assign bus.o_cap_en  = r_iss_dly[MAC_LAT-1];
      assign bus.o_cap_sel = r_sel_dly[MAC_LAT-1];
    end
  endgenerate

`ifdef FFT_COL_SCHED_PERF_EN
  logic [15:0] r_perf_cnt, r_perf_cycles;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_cnt    <= '0;
      r_perf_cycles <= '0;
    end else begin
      if (r_state == S_IDLE)
        r_perf_cnt <= '0;
      else if (w_busy && r_perf_cnt != 16'hFFFF)
        r_perf_cnt <= r_perf_cnt + 16'd1;
      // Include the final DRAIN cycle, which the counter has not yet absorbed.
      if (r_state == S_DRAIN && w_state_next == S_DONE)
        r_perf_cycles <= (r_perf_cnt == 16'hFFFF) ? r_perf_cnt : r_perf_cnt + 16'd1;
    end
  end
  assign bus.o_perf_cycles = r_perf_cycles;
`else
  assign bus.o_perf_cycles = '0;
`endif

  assign bus.o_mac_sel   = w_mac_sel;
  assign bus.o_tw_idx    = w_tw_idx;
  assign bus.o_stage     = r_stage;
  assign bus.o_ld_en     = w_ld_en;
  assign bus.o_issue     = w_issue;
  assign bus.o_bank_swap = w_bank_swap;
  assign bus.o_busy      = w_busy;
  assign bus.o_done      = w_done;
endmodule

// File: tb/tb_fft_col_sched.sv
// Scoreboard bench for fft_col_sched: stimulus pushes cycle-stamped expected events,
// a negedge monitor pops and compares them as the DUT raises each strobe.
module tb_fft_col_sched;
  localparam int MAC_LAT = 1;
  localparam int STG_LEN = 4 + MAC_LAT + 1;
`ifdef FFT_COL_SCHED_PERF_EN
  localparam int PERF_EXP = 19;
`else
  localparam int PERF_EXP = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_col_sched_if bus ();
  fft_col_sched dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {int cyc; int a; int b; int c;} ev_t;
  ev_t q_ld[$], q_iss[$], q_cap[$], q_bs[$], q_done[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  int tw_tab [3][4] = '{'{0, 4, 0, 4}, '{0, 2, 4, 6}, '{0, 1, 2, 3}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL unexpected_%s: got 1 expected 0 (cycle %0d)", name, cyc);
  endtask

  // Push every event of a run started at cycle c whose cycle is below stop.
  task automatic expect_run(input int c, input int stop);
    int t;
    if (c + 1 < stop) q_ld.push_back('{c + 1, 0, 0, 0});
    for (int s = 0; s < 3; s++) begin
      for (int p = 0; p < 4; p++) begin
        t = c + 2 + s * STG_LEN + p;
        if (t < stop) q_iss.push_back('{t, p, tw_tab[s][p], s});
        if (t + MAC_LAT < stop) q_cap.push_back('{t + MAC_LAT, p, 0, 0});
      end
      t = c + 2 + s * STG_LEN + 4 + MAC_LAT;
      if (s < 2 && t < stop) q_bs.push_back('{t, s, 0, 0});
    end
    if (c + 2 + 3 * STG_LEN < stop) q_done.push_back('{c + 2 + 3 * STG_LEN, 0, 0, 0});
  endtask

  always begin : mon
    ev_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.o_ld_en) busy_cnt = 1;
      else if (bus.o_busy) busy_cnt++;
      if (bus.o_ld_en) begin
        if (q_ld.size() == 0) unexpected("ld_en");
        else begin
          e = q_ld.pop_front();
          chk("ld_cyc", cyc, e.cyc);
          $display("ld    cyc=%0d", cyc);
        end
      end
      if (bus.o_issue) begin
        if (q_iss.size() == 0) unexpected("issue");
        else begin
          e = q_iss.pop_front();
          chk("issue_cyc", cyc, e.cyc);
          chk("mac_sel", int'(bus.o_mac_sel), e.a);
          chk("tw_idx", int'(bus.o_tw_idx), e.b);
          chk("issue_stage", int'(bus.o_stage), e.c);
          $display("issue cyc=%0d stage=%0d sel=%0d tw=%0d", cyc, bus.o_stage, bus.o_mac_sel, bus.o_tw_idx);
        end
      end
      if (bus.o_cap_en) begin
        if (q_cap.size() == 0) unexpected("cap_en");
        else begin
          e = q_cap.pop_front();
          chk("cap_cyc", cyc, e.cyc);
          chk("cap_sel", int'(bus.o_cap_sel), e.a);
          $display("cap   cyc=%0d sel=%0d", cyc, bus.o_cap_sel);
        end
      end
      if (bus.o_bank_swap) begin
        if (q_bs.size() == 0) unexpected("bank_swap");
        else begin
          e = q_bs.pop_front();
          chk("swap_cyc", cyc, e.cyc);
          chk("swap_stage", int'(bus.o_stage), e.a);
          $display("swap  cyc=%0d stage=%0d", cyc, bus.o_stage);
        end
      end
      if (bus.o_done && !prev_done) begin
        if (q_done.size() == 0) unexpected("done");
        else begin
          e = q_done.pop_front();
          chk("done_cyc", cyc, e.cyc);
          $display("done  cyc=%0d", cyc);
        end
      end
      prev_done = bus.o_done;
    end
  end

  task automatic start_run(output int c);
    @(negedge clk);
    c = cyc;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = bus.o_done;
    end
    chk("done_timeout", int'(seen), 1);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 60 && cyc < target; i++) @(negedge clk);
    chk("reach_cycle", cyc, target);
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.i_ack = 1'b1;
    @(negedge clk);
    bus.i_ack = 1'b0;
  endtask

  initial begin
    int c;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_ack   = 1'b0;
    #1;
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_done", int'(bus.o_done), 0);
    chk("rst_issue", int'(bus.o_issue), 0);
    chk("rst_cap_en", int'(bus.o_cap_en), 0);
    chk("rst_stage", int'(bus.o_stage), 0);
    chk("rst_perf", int'(bus.o_perf_cycles), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Full transform
    start_run(c);
    expect_run(c, 1 << 30);
    wait_done();
    chk("busy_cycles", busy_cnt, 19);
    chk("perf_first", int'(bus.o_perf_cycles), PERF_EXP);

    // Held DONE with start pulses, then ack together with start
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.i_start = (i % 3 == 0);
      #2;
      chk("done_hold", int'(bus.o_done), 1);
      chk("done_busy", int'(bus.o_busy), 0);
    end
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_ack   = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_ack   = 1'b0;
    #2;
    chk("ack_done_low", int'(bus.o_done), 0);
    chk("ack_idle_busy", int'(bus.o_busy), 0);
    @(negedge clk);
    #2;
    chk("ack_no_start", int'(bus.o_busy), 0);

    // Abort in stage 1 RUN phase 2
    start_run(c);
    expect_run(c, c + 11);
    wait_cyc(c + 10);
    bus.i_abort = 1'b1;
    #2;
    chk("abort_at_sel", int'(bus.o_mac_sel), 2);
    chk("abort_at_stage", int'(bus.o_stage), 1);
    @(negedge clk);
    bus.i_abort = 1'b0;
    #2;
    chk("abort_busy", int'(bus.o_busy), 0);
    chk("abort_issue", int'(bus.o_issue), 0);
    chk("abort_done", int'(bus.o_done), 0);
    repeat (5) @(negedge clk);
    chk("perf_after_abort", int'(bus.o_perf_cycles), PERF_EXP);

    // Fresh full transform after abort
    start_run(c);
    expect_run(c, 1 << 30);
    wait_done();
    chk("busy_cycles_2", busy_cnt, 19);
    do_ack();

    // Asynchronous reset during the first DRAIN cycle of stage 0
    start_run(c);
    expect_run(c, c + 7);
    wait_cyc(c + 6);
    #1;
    chk("pre_rst_busy", int'(bus.o_busy), 1);
    chk("pre_rst_issue", int'(bus.o_issue), 0);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_busy", int'(bus.o_busy), 0);
    chk("arst_cap_en", int'(bus.o_cap_en), 0);
    chk("arst_cap_sel", int'(bus.o_cap_sel), 0);
    chk("arst_mac_sel", int'(bus.o_mac_sel), 0);
    chk("arst_tw", int'(bus.o_tw_idx), 0);
    chk("arst_swap", int'(bus.o_bank_swap), 0);
    chk("arst_done", int'(bus.o_done), 0);
    chk("arst_perf", int'(bus.o_perf_cycles), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2;
    chk("post_rst_stage", int'(bus.o_stage), 0);
    chk("post_rst_busy", int'(bus.o_busy), 0);
    repeat (3) @(negedge clk);
    chk("queues_empty", q_ld.size() + q_iss.size() + q_cap.size() + q_bs.size() + q_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_col_sched.md
Name: fft_col_sched

Overview:
- Sequencer for a radix-2 FFT column built from NUM_MACS parallel complex MAC units that share one 2-bit phase select for their input mux, twiddle mux and output demux.
- Accepts a start request and latches the input bank, then steps the phase select through every phase of every stage.
- Generates the twiddle index and output-capture strobes, swaps banks between stages, and signals done with a done/ack handshake.
- Sits between the top-level FFT control and the MAC column datapath.

Parameters:
- PHASES, 4: phases per stage; sel width = clog2(PHASES).
- NUM_STAGES, 3: butterfly stages per transform.
- MAC_LAT, 1: MAC pipeline latency in cycles, 0..7.
- TW_W, 3: twiddle index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  request a transform; sampled only in IDLE.
- abort  in  1  synchronous abort; return to IDLE next cycle.
- ack  in  1  consumer acknowledges done.
- mac_sel  out  clog2(PHASES)  phase select to MAC muxes/demuxes.
- tw_idx  out  TW_W  twiddle ROM index.
- stage  out  clog2(NUM_STAGES)  current stage number.
- ld_en  out  1  latch external input into input bank.
- issue  out  1  MAC operands valid this cycle.
- cap_en  out  1  write MAC results into output bank.
- cap_sel  out  clog2(PHASES)  demux slot for cap_en.
- bank_swap  out  1  output bank becomes next-stage input.
- busy  out  1  transform in progress.
- done  out  1  result valid, held until ack.
- perf_cycles  out  16  last-run cycle count (optional feature).

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; phase, stage and the delay line cleared.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: busy=0. start=1 -> LOAD.
- LOAD: exactly 1 cycle; ld_en=1; stage=0, phase=0 -> RUN.
- RUN:
  - issue=1; mac_sel=phase; phase+1 each cycle.
  - At phase=PHASES-1 -> DRAIN; phase wraps to 0.
- DRAIN:
  - Exactly MAC_LAT+1 cycles; issue=0.
  - In the last DRAIN cycle: if stage<NUM_STAGES-1, bank_swap=1, stage+1, -> RUN; otherwise -> DONE.
- DONE: done=1, busy=0; stays until ack=1 -> IDLE. start is ignored in DONE, including start and ack in the same cycle.
- busy=1 in LOAD, RUN and DRAIN.
- mac_sel, tw_idx, ld_en, issue and bank_swap are 0 outside their states.
- Capture path:
  - cap_en and cap_sel are issue and mac_sel delayed by exactly MAC_LAT cycles through a shift register.
  - With MAC_LAT=0 they are combinationally equal to issue and mac_sel.
  - Every issued phase produces exactly one cap_en before bank_swap.
- Twiddle: tw_idx = (phase << (NUM_STAGES-1-stage)) truncated to TW_W bits.
  - Stage 0: 0,4,0,4.
  - Stage 1: 0,2,4,6.
  - Stage 2: 0,1,2,3.
- abort=1 in any non-IDLE state: next state IDLE; done is not asserted; the delay line is flushed (no cap_en after abort).
- abort has priority over ack and state advance. abort in IDLE has no effect.
- Total busy cycles = 1 + NUM_STAGES*(PHASES+MAC_LAT+1). The default is 19.

Optional Feature:
- FFT_COL_SCHED_PERF_EN defined:
  - A 16-bit counter counts busy cycles, saturating at 0xFFFF.
  - perf_cycles loads the count on entry to DONE and holds it until the next DONE entry.
  - Aborted runs do not update perf_cycles.
  - Reset clears it.
- Not defined: perf_cycles is constant 0 and no counter logic exists.

Test Plan:
- Defaults; start pulse in IDLE ->
  - ld_en for 1 cycle.
  - Stage 0 mac_sel 0,1,2,3 with tw_idx 0,4,0,4.
  - done rises 19 cycles after LOAD entry, with busy high 19 cycles.
- MAC_LAT=1 -> cap_en/cap_sel trail issue/mac_sel by 1 cycle, 4 captures per stage; bank_swap exactly twice, each in the second DRAIN cycle.
- Hold ack=0 for 10 cycles in DONE -> done stays 1; start pulses ignored; ack=1 -> IDLE next cycle, done=0.
- abort asserted in stage 1 RUN phase 2 -> IDLE next cycle; no further cap_en, no done; a new start runs a full 19-cycle transform.
- reset driven low mid-DRAIN, between clock edges -> all outputs 0 immediately; after release, IDLE with stage=0.
- With FFT_COL_SCHED_PERF_EN -> perf_cycles=19 after first run; unchanged after an aborted run; 0 after reset.
